fifo_serializer: RTL and testbench

Downstream consumer stage for a pop-interface FIFO. It pops one IN_WIDTH-bit word at a time from the FIFO's empty/pop/data port and emits it as RATIO narrower OUT_WIDTH-bit beats on a valid/ready stream, marking the final beat of each word with `last_o`. It reloads back-to-back from the FIFO with no bubble, so a full FIFO drains at one beat per cycle under constant `ready_i`.

---
 rtl/fifo_serializer.sv | 130 +++++++++++++
 tb/tb_fifo_serializer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serializer.sv
// Purpose : pops IN_WIDTH-bit words from a pop-style FIFO and emits each as RATIO OUT_WIDTH-bit beats.
// Latency : FIFO non-empty in IDLE at cycle t -> pop at t, first beat valid at t+1; back-to-back reload, no bubble.
// Backpr. : ready_i low holds the current beat stable with valid_o high; no pop happens until the last beat is taken.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             discard held word, return to IDLE (priority below reset only)
//   fifo_empty_i        upstream FIFO empty flag
//   fifo_data_i         upstream FIFO head word
//   fifo_pop_o          pop strobe to the FIFO (combinational)
//   valid_o / ready_i   output beat handshake
//   data_o              current beat
//   last_o              current beat is the final beat of its word
//
// Build option: define FIFO_SERIALIZER_MSB_FIRST_EN to emit the most-significant
// slice first; default build emits the least-significant slice first.

module fifo_serializer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
    parameter int CNT_WIDTH = $clog2(RATIO)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 fifo_empty_i,
    input  logic [IN_WIDTH-1:0]  fifo_data_i,
    output logic                 fifo_pop_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 last_o
);

    if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_err_div
        $error("fifo_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (RATIO < 2) begin : g_err_ratio
        $error("fifo_serializer: RATIO must be at least 2");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_valid;
    logic [IN_WIDTH-1:0]    r_word;
    logic [CNT_WIDTH-1:0]   r_cnt;

    logic                   w_last;
    logic                   w_hs;
    logic                   w_pop;
    logic [OUT_WIDTH-1:0]   w_beat;

    // last_o is qualified by state so it reads 0 whenever no beat is presented.
    assign w_last = (r_state == S_SEND) && (r_cnt == CNT_WIDTH'(RATIO - 1));
    assign w_hs   = r_valid && ready_i;

    // Pop either to start from IDLE or to reload on the last-beat handshake,
    // which is what gives the bubble-free drain. Reset and flush veto it.
    assign w_pop  = !rst_i && !flush_i && !fifo_empty_i &&
                    ((r_state == S_IDLE) || (w_hs && w_last));

    // Beat select as a mux over constant slices keeps every part-select static.
    always_comb begin
        w_beat = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (r_cnt == CNT_WIDTH'(i)) begin
`ifdef FIFO_SERIALIZER_MSB_FIRST_EN
                w_beat = r_word[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
`else
                w_beat = r_word[i*OUT_WIDTH +: OUT_WIDTH];
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_word  <= '0;
            r_cnt   <= '0;
        end else if (flush_i) begin
            // A beat handshaked this cycle is already delivered; the rest of
            // the word is dropped.
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_word  <= fifo_data_i;
                        r_cnt   <= '0;
                        r_state <= S_SEND;
                        r_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (!w_last) begin
                            r_cnt <= r_cnt + CNT_WIDTH'(1);
                        end else if (w_pop) begin
                            r_word <= fifo_data_i;
                            r_cnt  <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign fifo_pop_o = w_pop;
    assign valid_o    = r_valid;
    assign data_o     = w_beat;
    assign last_o     = w_last;

endmodule

// File: tb/tb_fifo_serializer.sv
// Purpose : directed self-checking bench for fifo_serializer (32-bit words, 8-bit beats).
// Latency : inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
// Backpr. : ready_i is driven per scenario to exercise stalls, flush and reset mid-word.

module tb_fifo_serializer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        fifo_empty_i;
    logic [31:0] fifo_data_i;
    logic        fifo_pop_o;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  data_o;
    logic        last_o;

    int checks = 0;
    int errors = 0;

    // Expected beat orders, written out by hand for each word.
`ifdef FIFO_SERIALIZER_MSB_FIRST_EN
    localparam logic [7:0] BEATS_A1B2 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    localparam logic [7:0] BEATS_TWO  [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    localparam logic [7:0] BEATS_BAD  [4] = '{8'h0B, 8'hAD, 8'hF0, 8'h0D};
`else
    localparam logic [7:0] BEATS_A1B2 [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    localparam logic [7:0] BEATS_TWO  [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    localparam logic [7:0] BEATS_BAD  [4] = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
`endif

    always #5 clk_i = ~clk_i;

    fifo_serializer #(
        .IN_WIDTH  (32),
        .OUT_WIDTH (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .last_o       (last_o)
    );

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Reset; pop must stay low during reset even with data waiting.
    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; fifo_empty_i = 1'b0;
        fifo_data_i = 32'hCAFEF00D; ready_i = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        checks++;
        if (fifo_pop_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_pop got %b exp 0", fifo_pop_o);
        end
        next_cycle();
        rst_i = 1'b0; fifo_empty_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({valid_o, last_o, fifo_pop_o, data_o} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs got v=%b l=%b p=%b d=%h exp all 0",
                     valid_o, last_o, fifo_pop_o, data_o);
        end
        next_cycle();
    endtask

    // One word, ready held high: pop, four beats, then IDLE.
    task automatic test_single_word();
        fifo_empty_i = 1'b0; fifo_data_i = 32'hA1B2C3D4; ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({valid_o, fifo_pop_o} !== 2'b01) begin
            errors++;
            $display("FAIL single_pop got v=%b p=%b exp v=0 p=1", valid_o, fifo_pop_o);
        end
        next_cycle();
        fifo_empty_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            checks++;
            if ({valid_o, last_o, fifo_pop_o, data_o} !== {1'b1, (k == 3), 1'b0, BEATS_A1B2[k]}) begin
                errors++;
                $display("FAIL single_beat%0d got v=%b l=%b p=%b d=%h exp v=1 l=%b p=0 d=%h",
                         k, valid_o, last_o, fifo_pop_o, data_o, (k == 3), BEATS_A1B2[k]);
            end
            next_cycle();
        end
        @(negedge clk_i);
        checks++;
        if ({valid_o, fifo_pop_o} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle got v=%b p=%b exp 0 0", valid_o, fifo_pop_o);
        end
        next_cycle();
    endtask

    // Stall three cycles on the second beat while the FIFO has data: no pop.
    task automatic test_stall();
        fifo_empty_i = 1'b0; fifo_data_i = 32'hA1B2C3D4; ready_i = 1'b1;
        next_cycle();                       // pop cycle
        fifo_data_i = 32'hDEADBEEF;         // FIFO stays non-empty
        next_cycle();                       // beat 0 accepted
        ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk_i);
            checks++;
            if ({valid_o, last_o, fifo_pop_o, data_o} !== {3'b100, BEATS_A1B2[1]}) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b l=%b p=%b d=%h exp v=1 l=0 p=0 d=%h",
                         s, valid_o, last_o, fifo_pop_o, data_o, BEATS_A1B2[1]);
            end
            next_cycle();
        end
        ready_i = 1'b1; fifo_empty_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk_i);
            checks++;
            if ({valid_o, last_o, fifo_pop_o, data_o} !== {1'b1, (k == 3), 1'b0, BEATS_A1B2[k]}) begin
                errors++;
                $display("FAIL stall_beat%0d got v=%b l=%b p=%b d=%h exp v=1 l=%b p=0 d=%h",
                         k, valid_o, last_o, fifo_pop_o, data_o, (k == 3), BEATS_A1B2[k]);
            end
            next_cycle();
        end
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle got v=%b exp 0", valid_o);
        end
        next_cycle();
    endtask

    // Two words back to back: eight beats, second pop on the fourth beat.
    task automatic test_back_to_back();
        fifo_empty_i = 1'b0; fifo_data_i = 32'h11223344; ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (fifo_pop_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_pop got %b exp 1", fifo_pop_o);
        end
        next_cycle();
        fifo_data_i = 32'h55667788;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            checks++;
            if ({valid_o, last_o, fifo_pop_o, data_o} !==
                {1'b1, (k == 3 || k == 7), (k == 3), BEATS_TWO[k]}) begin
                errors++;
                $display("FAIL b2b_beat%0d got v=%b l=%b p=%b d=%h exp v=1 l=%b p=%b d=%h",
                         k, valid_o, last_o, fifo_pop_o, data_o,
                         (k == 3 || k == 7), (k == 3), BEATS_TWO[k]);
            end
            next_cycle();
            if (k == 3) fifo_empty_i = 1'b1;
        end
        @(negedge clk_i);
        checks++;
        if ({valid_o, fifo_pop_o} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle got v=%b p=%b exp 0 0", valid_o, fifo_pop_o);
        end
        next_cycle();
    endtask

    // Flush after the second beat, then flush coinciding with a last-beat handshake.
    task automatic test_flush();
        fifo_empty_i = 1'b0; fifo_data_i = 32'hA1B2C3D4; ready_i = 1'b1;
        next_cycle();                       // pop
        fifo_empty_i = 1'b1;
        next_cycle();                       // beat 0
        next_cycle();                       // beat 1
        flush_i = 1'b1; ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (fifo_pop_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_pop got %b exp 0", fifo_pop_o);
        end
        next_cycle();
        flush_i = 1'b0; ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            checks++;
            if ({valid_o, fifo_pop_o} !== 2'b00) begin
                errors++;
                $display("FAIL flush_idle%0d got v=%b p=%b exp 0 0", c, valid_o, fifo_pop_o);
            end
            next_cycle();
        end

        // New word must start again from beat 0.
        fifo_empty_i = 1'b0;
        next_cycle();                       // pop
        fifo_empty_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({valid_o, last_o, data_o} !== {2'b10, BEATS_A1B2[0]}) begin
            errors++;
            $display("FAIL flush_restart got v=%b l=%b d=%h exp v=1 l=0 d=%h",
                     valid_o, last_o, data_o, BEATS_A1B2[0]);
        end
        next_cycle();
        next_cycle();
        next_cycle();                       // last beat now presented
        fifo_empty_i = 1'b0; fifo_data_i = 32'h0BADF00D; flush_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({valid_o, last_o, fifo_pop_o} !== 3'b110) begin
            errors++;
            $display("FAIL flush_last got v=%b l=%b p=%b exp v=1 l=1 p=0",
                     valid_o, last_o, fifo_pop_o);
        end
        next_cycle();
        flush_i = 1'b0; fifo_empty_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({valid_o, fifo_pop_o} !== 2'b00) begin
            errors++;
            $display("FAIL flush_last_idle got v=%b p=%b exp 0 0", valid_o, fifo_pop_o);
        end
        next_cycle();
    endtask

    // Reset on the third beat with data waiting, then a clean restart.
    task automatic test_reset_mid_word();
        fifo_empty_i = 1'b0; fifo_data_i = 32'hA1B2C3D4; ready_i = 1'b1;
        next_cycle();                       // pop
        fifo_data_i = 32'h0BADF00D;
        next_cycle();                       // beat 0
        next_cycle();                       // beat 1
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({valid_o, fifo_pop_o, data_o} !== {2'b10, BEATS_A1B2[2]}) begin
            errors++;
            $display("FAIL rstmid_pop got v=%b p=%b d=%h exp v=1 p=0 d=%h",
                     valid_o, fifo_pop_o, data_o, BEATS_A1B2[2]);
        end
        next_cycle();
        rst_i = 1'b0; fifo_empty_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({valid_o, last_o, fifo_pop_o, data_o} !== 11'h000) begin
            errors++;
            $display("FAIL rstmid_outputs got v=%b l=%b p=%b d=%h exp all 0",
                     valid_o, last_o, fifo_pop_o, data_o);
        end
        next_cycle();
        fifo_empty_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (fifo_pop_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_repop got %b exp 1", fifo_pop_o);
        end
        next_cycle();
        fifo_empty_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            checks++;
            if ({valid_o, last_o, data_o} !== {1'b1, (k == 3), BEATS_BAD[k]}) begin
                errors++;
                $display("FAIL rstmid_beat%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         k, valid_o, last_o, data_o, (k == 3), BEATS_BAD[k]);
            end
            next_cycle();
        end
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle got v=%b exp 0", valid_o);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
